// File: rtl/gate_tt_checker.sv
// gate_tt_checker: sweeps a 2-input gate through 00,01,10,11 and checks y against the op function.
// Optional GATE_TT_LOG_EN enables per-sample and end-of-run simulation logging.
module gate_tt_checker #(
   parameter int unsigned SETTLE = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [2:0] op,
   input  logic       y,
   output logic       a,
   output logic       b,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [2:0] err_count,
   output logic [3:0] fail_mask,
   output logic       bad_op
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   localparam logic [3:0] CNT_LOAD = 4'(SETTLE - 1);
   state_t     state_q, state_d;
   logic [2:0] op_q, op_d;
   logic [1:0] v_q, v_d;
   logic [3:0] cnt_q, cnt_d;
   logic [2:0] err_q, err_d;
   logic [3:0] mask_q, mask_d;
   logic       pass_q, pass_d;
   logic       bad_q, bad_d;
   logic       sample, exp_y, mis;
   assign sample = (state_q == RUN) && (cnt_q == 4'd0);
   assign exp_y  = op_q == 3'd0 ? (v_q[1] & v_q[0]) :
                   op_q == 3'd1 ? (v_q[1] | v_q[0]) :
                   op_q == 3'd2 ? ~(v_q[1] & v_q[0]) :
                   op_q == 3'd3 ? ~(v_q[1] | v_q[0]) :
                   op_q == 3'd4 ? (v_q[1] ^ v_q[0]) : ~(v_q[1] ^ v_q[0]);
   assign mis = sample && (y != exp_y);
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      v_d     = v_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      mask_d  = mask_q;
      pass_d  = pass_q;
      bad_d   = bad_q;
      case (state_q)
         IDLE: if (start) begin
            op_d    = op;
            v_d     = 2'd0;
            cnt_d   = CNT_LOAD;
            err_d   = 3'd0;
            mask_d  = 4'd0;
            pass_d  = 1'b0;
            bad_d   = op > 3'd5;
            state_d = op > 3'd5 ? DONE : RUN;
         end
         RUN: begin
            err_d  = err_q + {2'b0, mis};
            mask_d = mask_q | ({3'b0, mis} << v_q);
            cnt_d  = sample ? CNT_LOAD : cnt_q - 4'd1;
            // pass uses the count including this final sample
            if (sample && v_q == 2'd3) begin
               state_d = DONE;
               pass_d  = err_d == 3'd0;
            end else if (sample) v_d = v_q + 2'd1;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         op_q    <= 3'd0;
         v_q     <= 2'd0;
         cnt_q   <= 4'd0;
         err_q   <= 3'd0;
         mask_q  <= 4'd0;
         pass_q  <= 1'b0;
         bad_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         v_q     <= v_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         mask_q  <= mask_d;
         pass_q  <= pass_d;
         bad_q   <= bad_d;
      end
   end
   assign a         = (state_q == RUN) & v_q[1];
   assign b         = (state_q == RUN) & v_q[0];
   assign busy      = state_q == RUN;
   assign done      = state_q == DONE;
   assign pass      = pass_q;
   assign err_count = err_q;
   assign fail_mask = mask_q;
   assign bad_op    = bad_q;
`ifdef GATE_TT_LOG_EN
   always @(posedge clk) begin
      if (sample) $display("gate_tt: a=%0b b=%0b y=%0b exp=%0b %s", a, b, y, exp_y, mis ? "FAIL" : "OK");
      if (done) $display("gate_tt: done pass=%0b err_count=%0d", pass, err_count);
   end
`else
`endif
endmodule

// File: tb/tb_gate_tt_checker.sv
// tb_gate_tt_checker: directed checks of gate_tt_checker around a modelled OR gate.
module tb_gate_tt_checker;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic [2:0] op = 3'd0;
   logic [1:0] mode = 2'd0;
   logic       y, a, b, busy, done, pass, bad_op;
   logic [2:0] err_count;
   logic [3:0] fail_mask;
   int         cmp = 0;
   int         errs = 0;
   always #5 clk = ~clk;
   // mode 0: OR gate, 1: stuck at 1, 2: stuck at 0
   assign y = mode == 2'd0 ? (a | b) : mode == 2'd1;
   gate_tt_checker #(.SETTLE(2)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .op(op), .y(y),
      .a(a), .b(b), .busy(busy), .done(done), .pass(pass),
      .err_count(err_count), .fail_mask(fail_mask), .bad_op(bad_op)
   );
   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      cmp++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic chk_idle_zero(input string tag);
      chk({tag, "_ab"}, {2'b0, a, b}, 4'd0);
      chk({tag, "_busy"}, {3'b0, busy}, 4'd0);
      chk({tag, "_done"}, {3'b0, done}, 4'd0);
      chk({tag, "_pass"}, {3'b0, pass}, 4'd0);
      chk({tag, "_err"}, {1'b0, err_count}, 4'd0);
      chk({tag, "_mask"}, fail_mask, 4'd0);
      chk({tag, "_bad"}, {3'b0, bad_op}, 4'd0);
   endtask
   task automatic run(input string tag, input logic [2:0] o, input logic dup,
                      input logic [2:0] e_err, input logic [3:0] e_mask, input logic e_pass);
      op = o;
      start = 1'b1;
      step();
      start = 1'b0;
      op = 3'd6;
      for (int k = 1; k <= 8; k++) begin
         chk($sformatf("%s_ab%0d", tag, k), {2'b0, a, b}, 4'((k - 1) / 2));
         chk($sformatf("%s_busy%0d", tag, k), {3'b0, busy}, 4'd1);
         chk($sformatf("%s_done%0d", tag, k), {3'b0, done}, 4'd0);
         if (dup && (k == 3 || k == 5)) start = 1'b1;
         step();
         start = 1'b0;
      end
      chk({tag, "_done"}, {3'b0, done}, 4'd1);
      chk({tag, "_busy_end"}, {3'b0, busy}, 4'd0);
      chk({tag, "_ab_end"}, {2'b0, a, b}, 4'd0);
      chk({tag, "_err"}, {1'b0, err_count}, {1'b0, e_err});
      chk({tag, "_mask"}, fail_mask, e_mask);
      chk({tag, "_pass"}, {3'b0, pass}, {3'b0, e_pass});
      chk({tag, "_bad"}, {3'b0, bad_op}, 4'd0);
      step();
      chk({tag, "_done_drop"}, {3'b0, done}, 4'd0);
      chk({tag, "_hold_mask"}, fail_mask, e_mask);
   endtask
   initial begin
      #3;
      chk_idle_zero("rst");
      step();
      step();
      rst_n = 1'b1;
      step();
      chk_idle_zero("post_rst");
      run("or_ok", 3'd1, 1'b0, 3'd0, 4'b0000, 1'b1);
      run("and_vs_or", 3'd0, 1'b0, 3'd2, 4'b0110, 1'b0);
      run("nand_vs_or", 3'd2, 1'b0, 3'd2, 4'b1001, 1'b0);
      run("xor_vs_or", 3'd4, 1'b0, 3'd1, 4'b1000, 1'b0);
      run("xnor_vs_or", 3'd5, 1'b0, 3'd3, 4'b0111, 1'b0);
      mode = 2'd1;
      run("stuck1_or", 3'd1, 1'b0, 3'd1, 4'b0001, 1'b0);
      mode = 2'd2;
      run("stuck0_nor", 3'd3, 1'b0, 3'd1, 4'b0001, 1'b0);
      mode = 2'd0;
      op = 3'd6;
      start = 1'b1;
      step();
      start = 1'b0;
      chk("bad_done", {3'b0, done}, 4'd1);
      chk("bad_busy", {3'b0, busy}, 4'd0);
      chk("bad_ab", {2'b0, a, b}, 4'd0);
      chk("bad_flag", {3'b0, bad_op}, 4'd1);
      chk("bad_pass", {3'b0, pass}, 4'd0);
      chk("bad_err", {1'b0, err_count}, 4'd0);
      chk("bad_mask", fail_mask, 4'd0);
      step();
      chk("bad_done_drop", {3'b0, done}, 4'd0);
      chk("bad_hold", {3'b0, bad_op}, 4'd1);
      chk("bad_ab2", {2'b0, a, b}, 4'd0);
      run("after_bad", 3'd1, 1'b0, 3'd0, 4'b0000, 1'b1);
      run("dup_start", 3'd1, 1'b1, 3'd0, 4'b0000, 1'b1);
      op = 3'd0;
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      step();
      step();
      chk("mid_ab", {2'b0, a, b}, 4'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk_idle_zero("mid_rst");
      step();
      chk_idle_zero("mid_rst_held");
      rst_n = 1'b1;
      step();
      run("after_rst", 3'd1, 1'b0, 3'd0, 4'b0000, 1'b1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
      $finish;
   end
endmodule
